// File: rtl/riscv_ctrl_pkg.sv
// Shared decode definitions for the pipelined RISC-V control path:
// opcode constants, ALUOp encodings and the control bundle carried down the pipe.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_ALU = 2'b10
   } alu_op_e;

   // Control bundle; EX/MEM reuses the same layout.
   typedef struct packed {
      alu_op_e    alu_op;
      logic [3:0] funct;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_ctrl_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode control stage.
interface id_ex_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      instr_i;
   logic             instr_valid_i;
   logic             flush_i;
   logic             stall_o;
   logic             ex_valid;
   logic [1:0]       ex_ALUOp;
   logic [3:0]       ex_Funct;
   logic             ex_RegWrite;
   logic             ex_MemRead;
   logic             ex_MemWrite;
   logic             ex_MemtoReg;
   logic             ex_ALUSrc;
   logic             ex_Branch;
   logic [4:0]       ex_rd;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic             ex_illegal;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output instr_i, instr_valid_i, flush_i,
      input  stall_o, ex_valid, ex_ALUOp, ex_Funct, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch, ex_rd, ex_rs1,
             ex_rs2, ex_illegal, stall_cnt
   );

   modport slave (
      input  instr_i, instr_valid_i, flush_i,
      output stall_o, ex_valid, ex_ALUOp, ex_Funct, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch, ex_rd, ex_rs1,
             ex_rs2, ex_illegal, stall_cnt
   );
endinterface

// File: rtl/main_decoder.sv
// Combinational main decoder: instruction word to control bundle, register
// indices and an illegal-opcode flag. Indices a class does not use are zeroed
// so the ID/EX register never carries immediate bits as register numbers.
module main_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        illegal,
   output logic        use_rs2,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
);

   logic unused_bits;
   assign unused_bits = ^{instr[31], instr[29:25]};

   // Opcode decode; every output defaulted first.
   always_comb begin
      ctrl    = CTRL_BUBBLE;
      illegal = 1'b0;
      use_rs2 = 1'b0;
      rd      = instr[11:7];
      rs1     = instr[19:15];
      rs2     = 5'd0;
      case (instr[6:0])
         OP_R: begin
            ctrl.alu_op    = ALUOP_ALU;
            ctrl.reg_write = 1'b1;
            ctrl.funct     = {instr[30], instr[14:12]};
            use_rs2        = 1'b1;
         end
         OP_I: begin
            // instr[30] is immediate data here, not a funct7 bit
            ctrl.alu_op    = ALUOP_ALU;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.funct     = {1'b0, instr[14:12]};
         end
         OP_LOAD: begin
            ctrl.alu_op     = ALUOP_MEM;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.funct      = {1'b0, instr[14:12]};
         end
         OP_STORE: begin
            ctrl.alu_op    = ALUOP_MEM;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.funct     = {1'b0, instr[14:12]};
            use_rs2        = 1'b1;
            rd             = 5'd0;
         end
         OP_BRANCH: begin
            ctrl.alu_op = ALUOP_BR;
            ctrl.branch = 1'b1;
            ctrl.funct  = {1'b0, instr[14:12]};
            use_rs2     = 1'b1;
            rd          = 5'd0;
         end
         default: begin
            illegal = 1'b1;
            rd      = 5'd0;
            rs1     = 5'd0;
         end
      endcase
      if (use_rs2) rs2 = instr[24:20];
   end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX control pipeline register with load-use stall detection, branch
// flush and a saturating stall-cycle counter.
module id_ex_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   id_ex_ctrl_if.slave  bus
);

   ctrl_t            dec_ctrl;
   logic             dec_illegal;
   logic             dec_use_rs2;
   logic [4:0]       dec_rd, dec_rs1, dec_rs2;

   logic             ex_valid_q, ex_valid_d;
   ctrl_t            ex_ctrl_q, ex_ctrl_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic [4:0]       ex_rs1_q, ex_rs1_d;
   logic [4:0]       ex_rs2_q, ex_rs2_d;
   logic             ex_illegal_q, ex_illegal_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stall;

   main_decoder u_dec (
      .instr   (bus.instr_i),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .use_rs2 (dec_use_rs2),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2)
   );

   // Load-use hazard against the load sitting in ID/EX; a flush overrides it.
   always_comb begin
      stall = ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != 5'd0) & bus.instr_valid_i
            & ((bus.instr_i[19:15] == ex_rd_q)
               | (dec_use_rs2 & (bus.instr_i[24:20] == ex_rd_q)))
            & ~bus.flush_i;
   end

   // Next ID/EX contents: bubble on flush, stall or empty slot; illegal opcodes
   // also become a bubble but raise the one-cycle illegal flag.
   always_comb begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = CTRL_BUBBLE;
      ex_rd_d      = 5'd0;
      ex_rs1_d     = 5'd0;
      ex_rs2_d     = 5'd0;
      ex_illegal_d = 1'b0;
      stall_cnt_d  = stall_cnt_q;
      if (!bus.flush_i && !stall && bus.instr_valid_i) begin
         if (dec_illegal) begin
            ex_illegal_d = 1'b1;
         end else begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = dec_ctrl;
            ex_rd_d    = dec_rd;
            ex_rs1_d   = dec_rs1;
            ex_rs2_d   = dec_rs2;
         end
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // ID/EX register and counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q   <= 1'b0;
         ex_ctrl_q    <= CTRL_BUBBLE;
         ex_rd_q      <= 5'd0;
         ex_rs1_q     <= 5'd0;
         ex_rs2_q     <= 5'd0;
         ex_illegal_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_rd_q      <= ex_rd_d;
         ex_rs1_q     <= ex_rs1_d;
         ex_rs2_q     <= ex_rs2_d;
         ex_illegal_q <= ex_illegal_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.stall_o     = stall;
   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_ALUOp    = ex_ctrl_q.alu_op;
   assign bus.ex_Funct    = ex_ctrl_q.funct;
   assign bus.ex_RegWrite = ex_ctrl_q.reg_write;
   assign bus.ex_MemRead  = ex_ctrl_q.mem_read;
   assign bus.ex_MemWrite = ex_ctrl_q.mem_write;
   assign bus.ex_MemtoReg = ex_ctrl_q.mem_to_reg;
   assign bus.ex_ALUSrc   = ex_ctrl_q.alu_src;
   assign bus.ex_Branch   = ex_ctrl_q.branch;
   assign bus.ex_rd       = ex_rd_q;
   assign bus.ex_rs1      = ex_rs1_q;
   assign bus.ex_rs2      = ex_rs2_q;
   assign bus.ex_illegal  = ex_illegal_q;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboard bench for id_ex_ctrl: each driven instruction pushes the expected
// ID/EX contents, popped and compared one edge later.
module tb_id_ex_ctrl;

   localparam int CNT_W = 4;

   localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_SUB  = 32'h402081B3; // sub  x3,x1,x2
   localparam logic [31:0] I_ADDI = 32'hFFF00293; // addi x5,x0,-1
   localparam logic [31:0] I_LW4  = 32'h0000A203; // lw   x4,0(x1)
   localparam logic [31:0] I_ADD6 = 32'h00220333; // add  x6,x4,x2
   localparam logic [31:0] I_LW0  = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADDZ = 32'h00000333; // add  x6,x0,x0
   localparam logic [31:0] I_SW   = 32'h0040A023; // sw   x4,0(x1)
   localparam logic [31:0] I_BEQ  = 32'h00220063; // beq  x4,x2,0
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   typedef struct packed {
      logic       valid;
      logic [1:0] alu_op;
      logic [3:0] funct;
      logic       rw, mr, mw, mtr, as, br;
      logic [4:0] rd, rs1, rs2;
      logic       ill;
   } exp_t;

   typedef struct packed {
      exp_t             b;
      logic [CNT_W-1:0] cnt;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   sb_t  sb_q[$];
   exp_t m;
   logic [CNT_W-1:0] m_cnt;
   exp_t obs_b;

   id_ex_ctrl_if #(.CNT_W(CNT_W)) bus ();

   id_ex_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   assign obs_b = {bus.ex_valid, bus.ex_ALUOp, bus.ex_Funct, bus.ex_RegWrite,
                   bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg, bus.ex_ALUSrc,
                   bus.ex_Branch, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_illegal};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
   endfunction

   // Reference decode written straight from the opcode table.
   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t e;
      e = '0;
      e.valid = 1'b1;
      e.rs1   = ins[19:15];
      e.rd    = ins[11:7];
      e.funct = {1'b0, ins[14:12]};
      case (ins[6:0])
         7'b0110011: begin e.alu_op = 2'b10; e.rw = 1; e.funct = {ins[30], ins[14:12]}; e.rs2 = ins[24:20]; end
         7'b0010011: begin e.alu_op = 2'b10; e.as = 1; e.rw = 1; end
         7'b0000011: begin e.alu_op = 2'b00; e.as = 1; e.mr = 1; e.mtr = 1; e.rw = 1; end
         7'b0100011: begin e.alu_op = 2'b00; e.as = 1; e.mw = 1; e.rd = 0; e.rs2 = ins[24:20]; end
         7'b1100011: begin e.alu_op = 2'b01; e.br = 1; e.rd = 0; e.rs2 = ins[24:20]; end
         default:    begin e = '0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic step(input string tag, input logic [31:0] ins, input logic vld,
                       input logic fl, input logic rst);
      logic exp_stall;
      exp_t nxt;
      sb_t  got;
      @(negedge clk);
      bus.instr_i       = ins;
      bus.instr_valid_i = vld;
      bus.flush_i       = fl;
      reset             = rst;
      #1;
      exp_stall = m.valid & m.mr & (m.rd != 5'd0) & vld & !fl
                & ((ins[19:15] == m.rd) | (uses_rs2(ins[6:0]) & (ins[24:20] == m.rd)));
      chk({tag, ".stall_o"}, 32'(bus.stall_o), 32'(exp_stall));
      if (rst) begin
         nxt   = '0;
         m_cnt = '0;
      end else begin
         if (fl || exp_stall || !vld) nxt = '0;
         else nxt = ref_decode(ins);
         if (exp_stall && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
      end
      m = nxt;
      sb_q.push_back('{b: nxt, cnt: m_cnt});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_underflow"}, 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         chk({tag, ".ex_bundle"}, 32'(obs_b), 32'(got.b));
         chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(got.cnt));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m     = '0;
      m_cnt = '0;
      reset = 1'b1;
      bus.instr_i       = 32'd0;
      bus.instr_valid_i = 1'b0;
      bus.flush_i       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.ex_bundle", 32'(obs_b), 32'd0);
      chk("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);

      step("rst_hold", I_ADD,  1, 0, 1);
      step("add",      I_ADD,  1, 0, 0);
      step("sub",      I_SUB,  1, 0, 0);
      step("addi",     I_ADDI, 1, 0, 0);

      step("lw4",      I_LW4,  1, 0, 0);
      step("use_stl",  I_ADD6, 1, 0, 0);
      step("use_go",   I_ADD6, 1, 0, 0);
      chk("stall_cnt_one", 32'(bus.stall_cnt), 32'd1);

      step("lw0",      I_LW0,  1, 0, 0);
      step("use_x0",   I_ADDZ, 1, 0, 0);

      step("lw4_sw",   I_LW4,  1, 0, 0);
      step("sw_stl",   I_SW,   1, 0, 0);
      step("sw_go",    I_SW,   1, 0, 0);

      step("lw4_fl",   I_LW4,  1, 0, 0);
      step("beq_fl",   I_BEQ,  1, 1, 0);
      step("beq",      I_BEQ,  1, 0, 0);

      step("ill",      I_ILL,  1, 0, 0);
      step("ill_off",  I_ADD,  1, 0, 0);
      step("ill_fl",   I_ILL,  1, 1, 0);
      step("ill_inv",  I_ILL,  0, 0, 0);

      step("lw4_inv",  I_LW4,  1, 0, 0);
      step("inv_use",  I_ADD6, 0, 0, 0);

      step("lw4_rst",  I_LW4,  1, 0, 0);
      step("stl_rst",  I_ADD6, 1, 0, 1);
      step("post_rst", I_ADD6, 1, 0, 0);

      for (int i = 0; i < 18; i++) begin
         step("sat_lw",  I_LW4,  1, 0, 0);
         step("sat_stl", I_ADD6, 1, 0, 0);
         step("sat_go",  I_ADD6, 1, 0, 0);
      end
      chk("cnt_saturated", 32'(bus.stall_cnt), 32'((1 << CNT_W) - 1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Decode-stage control generator and ID/EX control pipeline register for the pipelined RISC-V core. It turns the IF/ID instruction word into the `ALUOp`/`Funct` pair consumed by the ALU control decoder in EX, plus the datapath control bits. It registers all of them into the ID/EX stage, with load-use stall detection, branch flush and a saturating stall counter. It sits between the IF/ID register and the EX stage.

## Interface
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `instr_i` in 32: instruction from IF/ID.
- `instr_valid_i` in 1: IF/ID holds a real instruction.
- `flush_i` in 1: branch taken in EX; squash the instruction in ID.
- `stall_o` out 1: combinational; hold PC and IF/ID this cycle.
- `ex_valid` out 1: registered; ID/EX holds a real instruction.
- `ex_ALUOp` out 2: registered; 00 add (load/store), 01 branch, 10 R/I-ALU.
- `ex_Funct` out 4: registered; `{funct7[5], funct3}`.
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg`, `ex_ALUSrc`, `ex_Branch` out 1 each: registered control bits.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5 each: registered register indices.
- `ex_illegal` out 1: registered; one-cycle pulse for an unsupported opcode.
- `stall_cnt` out `CNT_W`: registered count of stall cycles, saturating.

## Operation
- Decoding is by opcode `instr_i[6:0]`:
  - R `0110011`: ALUOp=10, RegWrite=1.
  - I-ALU `0010011`: ALUOp=10, ALUSrc=1, RegWrite=1.
  - Load `0000011`: ALUOp=00, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1.
  - Store `0100011`: ALUOp=00, ALUSrc=1, MemWrite=1.
  - Branch `1100011`: ALUOp=01, Branch=1.
- `Funct = {instr[30], instr[14:12]}` for R-type.
- For I-ALU, bit 3 is forced to 0, because `instr[30]` is immediate there.
- For load, store and branch, `Funct = {0, funct3}`.
- rs2 is used only by R, store and branch. rs1 is used by all five classes.
- Any other opcode is illegal: ID/EX loads a bubble and `ex_illegal`=1.
- Bubble: `ex_valid`=0, all control bits 0, ALUOp=00, Funct=0, indices 0.
- Load-use hazard: `stall_o` = `ex_valid & ex_MemRead & ex_rd!=0 & instr_valid_i & ((rs1==ex_rd) | (rs2 used & rs2==ex_rd))`.
- When `stall_o`=1, ID/EX loads a bubble next edge. The bubble clears MemRead, so a load-use stall lasts exactly one cycle.
- Priority per edge: reset > flush_i > stall > normal load.
  - `flush_i` loads a bubble and forces `stall_o`=0 in the same cycle.
  - A flushed illegal instruction does not raise `ex_illegal`.
- `instr_valid_i`=0 loads a bubble. Such a bubble never stalls and never flags illegal.
- `stall_cnt` increments on each edge where `stall_o`=1 and neither reset nor flush is active. It holds at all-ones.

## Timing
- Decode to ID/EX latency is one cycle: an instruction present at edge N appears on the `ex_*` outputs after edge N.
- `stall_o` is valid in the same cycle, with no register in the path.
- Reset values: every registered output is 0, including `ex_valid`, `ex_illegal` and `stall_cnt`.
- A reset asserted mid-stall clears ID/EX, so `stall_o` drops in the cycle after reset.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUOp encodings (ALUOP_MEM=00, ALUOP_BR=01, ALUOP_ALU=10);
  - a packed control-bundle struct reused by EX/MEM.
- One combinational sub-module, `main_decoder`, maps instruction to control bundle plus an illegal flag.
- The top level holds the hazard logic, the ID/EX register and the counter.

## Test plan
- `add x3,x1,x2` (`0x002081B3`) valid -> next cycle: ALUOp=10, Funct=0000, RegWrite=1, rd=3, `ex_valid`=1.
- `sub x3,x1,x2` then `addi x5,x0,-1` -> Funct=1000 for the sub, then Funct=0000 with ALUSrc=1; confirms the bit-30 mask.
- `lw x4,0(x1)` then `add x6,x4,x2` -> `stall_o`=1 for exactly one cycle, one bubble in ID/EX, `stall_cnt`=1, then the add issues.
- A load to x0 followed by a use of x0 -> no stall.
- `beq` with `flush_i`=1 while a load-use condition holds -> `stall_o`=0, bubble loaded, `stall_cnt` unchanged.
- Opcode `1111111` -> `ex_illegal` pulses 1 for one cycle with `ex_valid`=0.
- Same opcode with `flush_i`=1 -> no illegal pulse.
- `reset` asserted mid-stream -> all outputs 0 after the edge.
- `stall_cnt` preset near all-ones by repeated stalls -> saturates and holds.
